// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Purpose  : Round-robin AHB-Lite arbiter sharing one bridge slave port among
//            NUM_M masters, with burst capping and parking on master 0.
// Revision : 1.0
// ============================================================================
module ahb_bus_arbiter #(
    parameter int NUM_M     = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                       Hclk,
    input  logic                       Hreset,
    input  logic [NUM_M-1:0]           M_Hbusreq,
    input  logic [NUM_M*AW-1:0]        M_Haddr,
    input  logic [NUM_M-1:0]           M_Hwrite,
    input  logic [NUM_M*2-1:0]         M_Htrans,
    input  logic [NUM_M*DW-1:0]        M_Hwdata,
    output logic [NUM_M-1:0]           M_Hgrant,
    output logic                       M_Hready,
    output logic [1:0]                 M_Hresp,
    output logic [DW-1:0]              M_Hrdata,
    output logic [$clog2(NUM_M)-1:0]   Hmaster,
    output logic [AW-1:0]              Haddr,
    output logic                       Hwrite,
    output logic [1:0]                 Htrans,
    output logic [DW-1:0]              Hwdata,
    output logic                       Hreadyin,
    input  logic                       Hreadyout,
    input  logic [1:0]                 Hresp,
    input  logic [DW-1:0]              Hrdata
);

    localparam int MW  = $clog2(NUM_M);
    localparam int BCW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_NONSEQ = 2'b10;
    localparam logic [1:0] c_SEQ    = 2'b11;

    typedef enum logic [0:0] {
        PARK = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    g_q, g_d;
    logic [MW-1:0]    d_q, d_d;
    logic [BCW-1:0]   bc_q, bc_d;

    logic [AW-1:0]    w_addr_g;
    logic             w_write_g;
    logic [1:0]       w_trans_g;
    logic [DW-1:0]    w_wdata_d;
    logic [MW-1:0]    w_idx;
    logic [MW-1:0]    w_rr_win;
    logic             w_rr_found;
    logic             w_others;
    logic             w_accept;
    logic             w_handover;

    always_comb begin
        w_addr_g  = M_Haddr[AW-1:0];
        w_write_g = M_Hwrite[0];
        w_trans_g = M_Htrans[1:0];
        w_wdata_d = M_Hwdata[DW-1:0];
        for (int i = 1; i < NUM_M; i++) begin
            if (g_q == MW'(i)) begin
                w_addr_g  = M_Haddr[i*AW +: AW];
                w_write_g = M_Hwrite[i];
                w_trans_g = M_Htrans[i*2 +: 2];
            end
            if (d_q == MW'(i)) begin
                w_wdata_d = M_Hwdata[i*DW +: DW];
            end
        end
    end

    // Cyclic search starting at g+1 so the current owner is considered last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_idx      = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            w_idx = MW'((int'(g_q) + k) % NUM_M);
            if (!w_rr_found && M_Hbusreq[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx;
            end
        end
    end

    assign M_Hgrant = NUM_M'(1) << g_q;
    assign w_others = |(M_Hbusreq & ~M_Hgrant);
    assign w_accept = Hreadyout && (state_q == OWN) && w_trans_g[1];

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        d_d        = d_q;
        bc_d       = bc_q;
        w_handover = 1'b0;
        if (Hreadyout) begin
            if (w_accept) begin
                d_d = g_q;
                if (w_trans_g == c_NONSEQ) begin
                    bc_d = BCW'(1);
                end else if (bc_q < BCW'(MAX_BURST)) begin
                    bc_d = bc_q + 1'b1;
                end
            end
            case (state_q)
                PARK: begin
                    if (w_rr_found) begin
                        state_d = OWN;
                        g_d     = w_rr_win;
                        bc_d    = '0;
                    end else begin
                        g_d = '0;
                    end
                end
                OWN: begin
                    // A SEQ beat that completes MAX_BURST beats ends the tenure when contended.
                    w_handover = !M_Hbusreq[g_q] || (w_trans_g == c_IDLE) ||
                                 (w_accept && (w_trans_g == c_SEQ) &&
                                  (bc_q >= BCW'(MAX_BURST - 1)) && w_others);
                    if (w_handover) begin
                        if (!w_rr_found) begin
                            state_d = PARK;
                            g_d     = '0;
                            bc_d    = '0;
                        end else if (w_rr_win != g_q) begin
                            g_d  = w_rr_win;
                            bc_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = PARK;
                    g_d     = '0;
                    bc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= PARK;
            g_q     <= '0;
            d_q     <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            d_q     <= d_d;
            bc_q    <= bc_d;
        end
    end

    assign Haddr    = w_addr_g;
    assign Hwrite   = w_write_g;
    assign Htrans   = ((state_q == OWN) && !Hreset) ? w_trans_g : c_IDLE;
    assign Hwdata   = w_wdata_d;
    assign Hmaster  = d_q;
    assign Hreadyin = Hreadyout;
    assign M_Hready = Hreadyout;
    assign M_Hresp  = Hresp;
    assign M_Hrdata = Hrdata;

endmodule

`default_nettype wire
